// File: rtl/ex_mem_if.sv
// Execute-to-memory pipeline bus: EX-side inputs, MEM-side outputs and the MAC feedback to EX.
// The pipeline register drives this bus through its slave modport.
interface ex_mem_if;
   logic        flush;
   logic [5:0]  stall;
   logic [4:0]  ex_wd;
   logic        ex_wreg;
   logic [31:0] ex_wdata;
   logic        ex_whilo;
   logic [31:0] ex_hi;
   logic [31:0] ex_lo;
   logic [63:0] ex_hilo_tmp;
   logic [1:0]  ex_cnt;
   logic [4:0]  mem_wd;
   logic        mem_wreg;
   logic [31:0] mem_wdata;
   logic        mem_whilo;
   logic [31:0] mem_hi;
   logic [31:0] mem_lo;
   logic [63:0] hilo_tmp_o;
   logic [1:0]  cnt_o;

   modport master (
      output flush, stall, ex_wd, ex_wreg, ex_wdata, ex_whilo, ex_hi, ex_lo, ex_hilo_tmp, ex_cnt,
      input  mem_wd, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo, hilo_tmp_o, cnt_o
   );

   modport slave (
      input  flush, stall, ex_wd, ex_wreg, ex_wdata, ex_whilo, ex_hi, ex_lo, ex_hilo_tmp, ex_cnt,
      output mem_wd, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo, hilo_tmp_o, cnt_o
   );
endinterface

// File: rtl/ex_mem.sv
// EX/MEM pipeline register with stall/flush handling and multiply-accumulate feedback to EX.
// Define EX_MEM_HILO_EN to build the HI/LO and MAC feedback registers; otherwise they read as 0.
module ex_mem (
   input  logic     clk,
   input  logic     rst,
   ex_mem_if.slave  bus
);
   logic [4:0]  mem_wd_reg;
   logic        mem_wreg_reg;
   logic [31:0] mem_wdata_reg;

   logic bubble;
   logic advance;

   // EX held while MEM runs on: MEM must see a nop this cycle.
   assign bubble  = bus.stall[3] & ~bus.stall[4];
   assign advance = ~bus.stall[3];

   always_ff @(posedge clk) begin
      if (rst || bus.flush || bubble) begin
         mem_wd_reg    <= '0;
         mem_wreg_reg  <= 1'b0;
         mem_wdata_reg <= '0;
      end else if (advance) begin
         mem_wd_reg    <= bus.ex_wd;
         mem_wreg_reg  <= bus.ex_wreg;
         mem_wdata_reg <= bus.ex_wdata;
      end
   end

   assign bus.mem_wd    = mem_wd_reg;
   assign bus.mem_wreg  = mem_wreg_reg;
   assign bus.mem_wdata = mem_wdata_reg;

`ifdef EX_MEM_HILO_EN
   logic        mem_whilo_reg;
   logic [31:0] mem_hi_reg;
   logic [31:0] mem_lo_reg;
   logic [63:0] hilo_tmp_reg;
   logic [1:0]  cnt_reg;

   always_ff @(posedge clk) begin
      if (rst || bus.flush) begin
         mem_whilo_reg <= 1'b0;
         mem_hi_reg    <= '0;
         mem_lo_reg    <= '0;
         hilo_tmp_reg  <= '0;
         cnt_reg       <= '0;
      end else if (bubble) begin
         // Keep the MAC partial product alive while EX repeats the instruction.
         mem_whilo_reg <= 1'b0;
         mem_hi_reg    <= '0;
         mem_lo_reg    <= '0;
         hilo_tmp_reg  <= bus.ex_hilo_tmp;
         cnt_reg       <= bus.ex_cnt;
      end else if (advance) begin
         mem_whilo_reg <= bus.ex_whilo;
         mem_hi_reg    <= bus.ex_hi;
         mem_lo_reg    <= bus.ex_lo;
         hilo_tmp_reg  <= '0;
         cnt_reg       <= '0;
      end
   end

   assign bus.mem_whilo  = mem_whilo_reg;
   assign bus.mem_hi     = mem_hi_reg;
   assign bus.mem_lo     = mem_lo_reg;
   assign bus.hilo_tmp_o = hilo_tmp_reg;
   assign bus.cnt_o      = cnt_reg;
`else
   assign bus.mem_whilo  = 1'b0;
   assign bus.mem_hi     = '0;
   assign bus.mem_lo     = '0;
   assign bus.hilo_tmp_o = '0;
   assign bus.cnt_o      = '0;
`endif
endmodule

// File: tb/tb_ex_mem.sv
// Self-checking bench for ex_mem: ordered vector table with hand-computed results plus short sequences.
// Expected HI/LO and MAC feedback values collapse to 0 when EX_MEM_HILO_EN is not defined.
module tb_ex_mem;
   logic clk = 1'b0;
   logic rst = 1'b1;
   ex_mem_if bus();

   ex_mem dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        flush;
      logic [5:0]  stall;
      logic [4:0]  wd;
      logic        wreg;
      logic [31:0] wdata;
      logic        whilo;
      logic [31:0] hi;
      logic [31:0] lo;
      logic [63:0] tmp;
      logic [1:0]  cnt;
      logic [4:0]  e_wd;
      logic        e_wreg;
      logic [31:0] e_wdata;
      logic        e_whilo;
      logic [31:0] e_hi;
      logic [31:0] e_lo;
      logic [63:0] e_tmp;
      logic [1:0]  e_cnt;
   } vec_t;

   vec_t vecs[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   function automatic vec_t mk(logic r, logic f, logic [5:0] s, logic [4:0] wd, logic wreg, logic [31:0] wdata,
                               logic whilo, logic [31:0] hi, logic [31:0] lo, logic [63:0] tmp, logic [1:0] cnt,
                               logic [4:0] e_wd, logic e_wreg, logic [31:0] e_wdata, logic e_whilo,
                               logic [31:0] e_hi, logic [31:0] e_lo, logic [63:0] e_tmp, logic [1:0] e_cnt);
      vec_t v;
      v.rst = r; v.flush = f; v.stall = s; v.wd = wd; v.wreg = wreg; v.wdata = wdata;
      v.whilo = whilo; v.hi = hi; v.lo = lo; v.tmp = tmp; v.cnt = cnt;
      v.e_wd = e_wd; v.e_wreg = e_wreg; v.e_wdata = e_wdata;
`ifdef EX_MEM_HILO_EN
      v.e_whilo = e_whilo; v.e_hi = e_hi; v.e_lo = e_lo; v.e_tmp = e_tmp; v.e_cnt = e_cnt;
`else
      v.e_whilo = 1'b0; v.e_hi = '0; v.e_lo = '0; v.e_tmp = '0; v.e_cnt = '0;
      if (e_whilo === 1'bx || e_hi === 'x || e_lo === 'x || e_tmp === 'x || e_cnt === 'x) v.e_cnt = '0;
`endif
      return v;
   endfunction

   task automatic check(string name, int row, logic [63:0] act, logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s (vector %0d): got %h, expected %h", name, row, act, exp);
      end
   endtask

   task automatic apply(vec_t v);
      rst             = v.rst;
      bus.flush       = v.flush;
      bus.stall       = v.stall;
      bus.ex_wd       = v.wd;
      bus.ex_wreg     = v.wreg;
      bus.ex_wdata    = v.wdata;
      bus.ex_whilo    = v.whilo;
      bus.ex_hi       = v.hi;
      bus.ex_lo       = v.lo;
      bus.ex_hilo_tmp = v.tmp;
      bus.ex_cnt      = v.cnt;
   endtask

   initial begin
      vec_t v;
      // rst flush stall wd wreg wdata whilo hi lo tmp cnt | expected wd wreg wdata whilo hi lo tmp cnt
      vecs.push_back(mk(1, 1, 6'h3F, 5'h1F, 1, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 2'd3, 0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 1, 6'h3F, 5'h1F, 1, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 2'd3, 0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 6'h00, 5, 1, 32'h1234_5678, 0, 0, 0, 0, 0, 5, 1, 32'h1234_5678, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 6'h00, 1, 1, 1, 1, 32'h11, 32'h22, 64'h5, 1, 1, 1, 1, 1, 32'h11, 32'h22, 0, 0));
      vecs.push_back(mk(0, 0, 6'h00, 2, 1, 2, 0, 0, 0, 0, 0, 2, 1, 2, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 6'h00, 3, 1, 3, 0, 0, 0, 0, 0, 3, 1, 3, 0, 0, 0, 0, 0));
      // bubble carrying MAC progress, then advance with ex_cnt=2
      vecs.push_back(mk(0, 0, 6'h0F, 7, 1, 32'h77, 1, 32'hAA, 32'hBB, 64'hDEAD_BEEF_0000_0001, 1, 0, 0, 0, 0, 0, 0, 64'hDEAD_BEEF_0000_0001, 1));
      vecs.push_back(mk(0, 0, 6'h00, 8, 1, 32'h88, 1, 32'hCC, 32'hDD, 64'h1234, 2, 8, 1, 32'h88, 1, 32'hCC, 32'hDD, 0, 0));
      // hold for three cycles while EX inputs change
      vecs.push_back(mk(0, 0, 6'h00, 9, 1, 32'hA5A5_A5A5, 1, 1, 2, 0, 0, 9, 1, 32'hA5A5_A5A5, 1, 1, 2, 0, 0));
      vecs.push_back(mk(0, 0, 6'h1F, 3, 0, 1, 0, 7, 7, 64'hFF, 2, 9, 1, 32'hA5A5_A5A5, 1, 1, 2, 0, 0));
      vecs.push_back(mk(0, 0, 6'h1F, 3, 0, 2, 0, 7, 7, 64'hFF, 2, 9, 1, 32'hA5A5_A5A5, 1, 1, 2, 0, 0));
      vecs.push_back(mk(0, 0, 6'h1F, 3, 0, 3, 0, 7, 7, 64'hFF, 2, 9, 1, 32'hA5A5_A5A5, 1, 1, 2, 0, 0));
      // consecutive bubbles re-sample; hold keeps feedback
      vecs.push_back(mk(0, 0, 6'h0F, 4, 1, 5, 1, 3, 3, 64'h0000_0001_0000_0002, 1, 0, 0, 0, 0, 0, 0, 64'h0000_0001_0000_0002, 1));
      vecs.push_back(mk(0, 0, 6'h0F, 4, 1, 6, 1, 3, 3, 64'h3, 2, 0, 0, 0, 0, 0, 0, 64'h3, 2));
      vecs.push_back(mk(0, 0, 6'h1F, 4, 1, 7, 1, 3, 3, 64'h9, 3, 0, 0, 0, 0, 0, 0, 64'h3, 2));
      // stall[4] alone still advances; full-width values
      vecs.push_back(mk(0, 0, 6'h10, 5'h1F, 1, 32'hCAFE, 1, 32'hFFFF_FFFF, 1, 64'h9, 3, 5'h1F, 1, 32'hCAFE, 1, 32'hFFFF_FFFF, 1, 0, 0));
      vecs.push_back(mk(0, 1, 6'h1F, 2, 1, 32'h11, 1, 4, 4, 64'h8, 1, 0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 6'h00, 4, 1, 32'h55, 1, 2, 3, 0, 0, 4, 1, 32'h55, 1, 2, 3, 0, 0));
      vecs.push_back(mk(0, 0, 6'h0F, 4, 1, 32'h55, 1, 2, 3, 64'hABC, 1, 0, 0, 0, 0, 0, 0, 64'hABC, 1));
      vecs.push_back(mk(0, 1, 6'h0F, 4, 1, 32'h55, 1, 2, 3, 64'hDEF, 2, 0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 6'h00, 6, 1, 32'h66, 1, 6, 6, 0, 0, 6, 1, 32'h66, 1, 6, 6, 0, 0));
      vecs.push_back(mk(1, 1, 6'h00, 6, 1, 32'h66, 1, 6, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      // reset abandons an in-flight MAC
      vecs.push_back(mk(0, 0, 6'h0F, 1, 1, 1, 0, 0, 0, 64'h77, 1, 0, 0, 0, 0, 0, 0, 64'h77, 1));
      vecs.push_back(mk(1, 0, 6'h1F, 1, 1, 1, 0, 0, 0, 64'h77, 1, 0, 0, 0, 0, 0, 0, 0, 0));
      // stall bits other than 3 and 4 are ignored
      vecs.push_back(mk(0, 0, 6'h27, 6, 1, 32'h600D, 0, 0, 0, 0, 0, 6, 1, 32'h600D, 0, 0, 0, 0, 0));

      apply(vecs[0]);
      for (int i = 0; i < vecs.size(); i++) begin
         v = vecs[i];
         @(negedge clk);
         apply(v);
         @(posedge clk);
         #1;
         check("mem_wd",    i, 64'(bus.mem_wd),    64'(v.e_wd));
         check("mem_wreg",  i, 64'(bus.mem_wreg),  64'(v.e_wreg));
         check("mem_wdata", i, 64'(bus.mem_wdata), 64'(v.e_wdata));
         check("mem_whilo", i, 64'(bus.mem_whilo), 64'(v.e_whilo));
         check("mem_hi",    i, 64'(bus.mem_hi),    64'(v.e_hi));
         check("mem_lo",    i, 64'(bus.mem_lo),    64'(v.e_lo));
         check("hilo_tmp",  i, bus.hilo_tmp_o,     v.e_tmp);
         check("cnt",       i, 64'(bus.cnt_o),     64'(v.e_cnt));
         $display("vec %0d: rst=%0b flush=%0b stall=%02h -> wd=%0d wreg=%0b wdata=%h whilo=%0b hi=%h lo=%h tmp=%h cnt=%0d",
                  i, v.rst, v.flush, v.stall, bus.mem_wd, bus.mem_wreg, bus.mem_wdata,
                  bus.mem_whilo, bus.mem_hi, bus.mem_lo, bus.hilo_tmp_o, bus.cnt_o);
      end

      // Output must not follow EX inputs until the next rising edge.
      @(negedge clk);
      bus.stall    = 6'h00;
      bus.ex_wd    = 5'd6;
      bus.ex_wdata = 32'hBEEF;
      #1;
      check("no_comb_path", 100, 64'(bus.mem_wdata), 64'h600D);
      @(posedge clk);
      #1;
      check("latency_1", 101, 64'(bus.mem_wdata), 64'hBEEF);
      $display("seq latency: mem_wdata=%h", bus.mem_wdata);

      // Two bubbles give two nop cycles, then the stream resumes.
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         bus.stall    = (k < 2) ? 6'h0F : 6'h00;
         bus.ex_wreg  = 1'b1;
         bus.ex_wdata = 32'h900 + 32'(k);
         @(posedge clk);
         #1;
         check("bubble_wreg", 110 + k, 64'(bus.mem_wreg), (k < 2) ? 64'd0 : 64'd1);
         check("bubble_wdata", 110 + k, 64'(bus.mem_wdata), (k < 2) ? 64'd0 : 64'h902);
         $display("seq bubble %0d: wreg=%0b wdata=%h", k, bus.mem_wreg, bus.mem_wdata);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/ex_mem.md
# ex_mem

Pipeline register between the execute stage and the memory-access stage of the five-stage MIPS core. Each clock it captures the execute result, destination register and HI/LO write request, and presents them to the memory stage one cycle later. It honours the core's stall vector and flush signal, inserting bubbles or holding state as required. It also carries the two-cycle multiply-accumulate intermediate result (`hilo_tmp`, `cnt`) back to the execute stage while that stage is stalled.

## Interface
Parameters: none. Widths come from the shared macros: RegBus = 32, RegAddrBus = 5.

- `clk`  in  1  rising-edge clock
- `rst`  in  1  reset; synchronous, active-high
- `flush`  in  1  exception flush; clears all pipeline outputs
- `stall`  in  6  stall vector from the pipeline control block; bit 3 = EX, bit 4 = MEM
- `ex_wd`  in  5  destination register address
- `ex_wreg`  in  1  register write enable
- `ex_wdata`  in  32  result to write
- `ex_whilo`  in  1  HI/LO write enable
- `ex_hi`, `ex_lo`  in  32 each  HI/LO values to write
- `ex_hilo_tmp`  in  64  multiply-accumulate partial product from EX
- `ex_cnt`  in  2  multiply-accumulate cycle count from EX
- `mem_wd`  out  5  registered `ex_wd`
- `mem_wreg`  out  1  registered `ex_wreg`
- `mem_wdata`  out  32  registered `ex_wdata`
- `mem_whilo`  out  1  registered `ex_whilo`
- `mem_hi`, `mem_lo`  out  32 each  registered `ex_hi` / `ex_lo`
- `hilo_tmp_o`  out  64  partial product fed back to EX
- `cnt_o`  out  2  cycle count fed back to EX

## Operation
- All state changes occur on the rising edge of `clk`. Outputs come directly from registers; there is no combinational path from input to output.
- Priority per edge, highest first:
  1. **rst**: every output is cleared to 0.
  2. **flush**: all `mem_*` outputs are cleared to 0. `hilo_tmp_o` and `cnt_o` are also cleared to 0.
  3. **Bubble** (`stall[3]`=1, `stall[4]`=0):
     - `mem_*` outputs are cleared to 0, so MEM sees a nop: `mem_wreg`=0, `mem_whilo`=0.
     - `hilo_tmp_o` ← `ex_hilo_tmp` and `cnt_o` ← `ex_cnt`. This preserves the multiply-accumulate progress while EX is held.
  4. **Advance** (`stall[3]`=0):
     - Each `mem_*` output takes its corresponding `ex_*` input.
     - `hilo_tmp_o` ← 0 and `cnt_o` ← 0.
  5. **Hold** (`stall[3]`=1, `stall[4]`=1): all outputs keep their current values.
- The block does not interpret `stall[0..2]` or `stall[5]`.
- No arithmetic is performed. All fields pass through at their full width, with no truncation or extension.

## Timing
- Latency is 1 cycle from `ex_*` to `mem_*` when advancing.
- A stall takes effect on the same edge where it is sampled high. A bubble occupies exactly one MEM cycle per edge during which the bubble condition holds.
- Simultaneous events:
  - `flush` with any stall value: flush wins.
  - `rst` with `flush`: reset wins. Both produce all-zero outputs.
- Reset mid-operation: an in-flight multiply-accumulate is abandoned, and `cnt_o` returns to 0 on the next edge.
- Consecutive bubbles re-sample `ex_hilo_tmp` and `ex_cnt` on every edge. The feedback value always reflects the most recent EX output.

## Configuration
- Macro: `EX_MEM_HILO_EN`.
- **Defined**: the HI/LO path and the multiply-accumulate feedback path (`mem_whilo`, `mem_hi`, `mem_lo`, `hilo_tmp_o`, `cnt_o`) are registered exactly as described above.
- **Undefined**: those registers are not instantiated. `mem_whilo`, `mem_hi`, `mem_lo`, `hilo_tmp_o` and `cnt_o` are tied to constant 0. Ports remain present so the top level is unchanged. The register-file path behaves identically in both builds.

## Test plan
- **Reset**: hold `rst`=1 for 2 cycles with all inputs = 1s → every output = 0. Release `rst` with `stall`=0 and `ex_wdata`=0x1234_5678, `ex_wd`=5, `ex_wreg`=1 → one cycle later `mem_wdata`=0x1234_5678, `mem_wd`=5, `mem_wreg`=1.
- **Advance stream**: drive `ex_wdata` = 1, 2, 3 on consecutive cycles with `stall`=0 → `mem_wdata` = 1, 2, 3, each one cycle delayed. `cnt_o` stays 0 throughout.
- **Bubble with MAC feedback**: `stall`=6'b001111, `ex_cnt`=1, `ex_hilo_tmp`=0xDEAD_BEEF_0000_0001 → `mem_wreg`=0, `mem_whilo`=0, `cnt_o`=1, `hilo_tmp_o`=0xDEAD_BEEF_0000_0001. Next cycle with `stall`=0 and `ex_cnt`=2 → `mem_*` take the EX values and `cnt_o`=0.
- **Hold**: register `mem_wdata`=0xA5A5_A5A5, then apply `stall`=6'b011111 for 3 cycles while `ex_wdata` changes → `mem_wdata` stays 0xA5A5_A5A5, and `cnt_o` and `hilo_tmp_o` are unchanged.
- **Flush priority**: `flush`=1 with `stall`=6'b011111 and nonzero outputs → all outputs = 0 on the next edge. Also assert `rst`=1 together with `flush`=1 → all outputs = 0.
- **Build without `EX_MEM_HILO_EN`**: `ex_whilo`=1, `ex_hi`=0xFFFF_FFFF, plus a bubble with `ex_cnt`=1 → `mem_whilo`=0, `mem_hi`=0, `cnt_o`=0. `mem_wdata` still passes through normally.
